spi_cursor_rx: RTL
==================

Name: spi_cursor_rx

Overview:
- Receives 32-bit cursor-position frames from the MCU over a chip-select-less SPI link and holds them in the vgaclk domain.
- Oversamples sck/sdi with clk, so it replaces the raw sck-clocked shift register that feeds videoGen.
- Validates each frame, clamps the position so the 12x8 cursor stays on screen, and publishes x_pos/y_pos only at the start of vertical sync. This prevents mid-frame cursor tearing.

Parameters:
- FRAME_BITS, 32: bits per SPI frame.
- TIMEOUT, 1024: clk cycles without an sck rising edge before a partial frame is discarded.
- X_LIM, 628: maximum published x (640-12).
- Y_LIM, 472: maximum published y (480-8).

Ports:
- clk  input  1  25.175 MHz vgaclk
- reset_n  input  1  asynchronous active-low reset
- sck  input  1  SPI clock from MCU, asynchronous, must be ≤ clk/4
- sdi  input  1  SPI data from MCU, MSB first, stable on sck rise
- vsync  input  1  active-low vertical sync from vgaController
- x_pos  output  10  published cursor x
- y_pos  output  10  published cursor y
- pos_valid  output  1  high once any position has been published
- frame_err  output  1  one-cycle pulse on a rejected frame
- timeout  output  1  one-cycle pulse when a partial frame is dropped
- frame_cnt  output  8  count of accepted frames, wraps at 256

Behaviour:
- Reset (async assert, sync release to clk):
  - x_pos=0, y_pos=0, pos_valid=0, frame_err=0, timeout=0, frame_cnt=0.
  - Bit counter=0, shift register=0, pending=0, vsync_d=1, idle counter=0.
  - Synchronizer flops for sck and sdi reset to 0.
  - Asserting reset mid-frame discards the partial frame.
- Input sampling:
  - sck and sdi each pass through a 2-flop synchronizer of equal depth, so they stay aligned.
  - sck_rise = synced sck high and previous synced sck low.
  - On sck_rise: shift = {shift[30:0], synced sdi}; bit counter increments.
- Frame complete: the sck_rise that brings the bit counter to FRAME_BITS.
  - Bit counter returns to 0.
  - The completed word W is the shift value including the current bit.
- Format check on W: bits [31:26] and [15:10] must be zero.
  - x field = W[25:16]; y field = W[9:0].
  - Fail: frame_err pulses high on the next cycle; pending and frame_cnt are unchanged.
  - Pass:
    - pend_x = min(x field, X_LIM).
    - pend_y = min(y field, Y_LIM).
    - pending=1; frame_cnt increments.
    - A newer frame overwrites an uncommitted one (last frame wins).
- Timeout:
  - Idle counter clears on every sck_rise. It increments while the bit counter is nonzero and saturates at TIMEOUT.
  - On reaching TIMEOUT: bit counter=0, timeout pulses for one cycle, idle counter clears.
  - The idle counter does not run while the bit counter is 0.
- Commit:
  - vsync_d registers vsync; vs_fall = vsync_d & ~vsync.
  - On a cycle with vs_fall and pending=1: at that clock edge x_pos<=pend_x, y_pos<=pend_y, pos_valid<=1, pending<=0.
  - Latency is one clk from vsync low at the input to new outputs.
  - vs_fall with pending=0: outputs hold.
- Simultaneous frame-complete and vs_fall:
  - Commit uses the pend values from before this cycle (if pending was set).
  - The new frame is loaded into pend and pending stays 1, to commit at the next vs_fall.
  - If pending was 0, the new frame waits for the next vs_fall.
- Outputs x_pos/y_pos are registered and hold between commits. pos_valid never deasserts except on reset.
- Width rules:
  - Comparisons are unsigned 10-bit.
  - The bit counter is $clog2(FRAME_BITS)+1 bits.
  - The idle counter is $clog2(TIMEOUT)+1 bits.

Test Plan:
- Send W=0x0064_00C8 (x=100, y=200) with sck=3 MHz, then pulse vsync low → x_pos=100, y_pos=200, pos_valid=1, one clk after vsync falls; frame_cnt=1.
- Send x=700, y=500 (W=0x02BC_01F4), then vsync → x_pos=628, y_pos=472.
- Send W=0x8064_00C8 (bit 31 set) → frame_err one-cycle pulse; frame_cnt, x_pos and y_pos unchanged after vsync.
- Clock 10 bits, idle 1100 clks, then send a full frame x=5, y=6 → timeout pulses once; after vsync x_pos=5, y_pos=6.
- Send x=10/y=20 then x=30/y=40 before vsync → after vsync x_pos=30, y_pos=40, frame_cnt=2.
- Align the final sck_rise of x=50/y=60 with vs_fall while pending holds x=30/y=40 → commit shows 30/40; the next vs_fall shows 50/60.
- Assert reset_n low after 16 bits → all outputs 0; the next full frame decodes correctly.

Source files
------------

// File: rtl/spi_cursor_rx.sv
// Oversampled SPI receiver for 32-bit cursor frames: validates, clamps to the
// visible area and publishes the position only at the start of vertical sync.
module spi_cursor_rx #(
  parameter int FRAME_BITS = 32,
  parameter int TIMEOUT    = 1024,
  parameter int X_LIM      = 628,
  parameter int Y_LIM      = 472
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       sdi,
  input  logic       vsync,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pos_valid,
  output logic       frame_err,
  output logic       timeout,
  output logic [7:0] frame_cnt
);
  localparam int BW = $clog2(FRAME_BITS) + 1;
  localparam int IW = $clog2(TIMEOUT) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
  localparam logic [9:0]    X_MAX    = 10'(X_LIM);
  localparam logic [9:0]    Y_MAX    = 10'(Y_LIM);

  // Reset asserts asynchronously but releases on a clk edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_i = rst_sync_q[1];

  logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
  logic sdi_meta_q, sdi_meta_d, sdi_sync_q, sdi_sync_d;
  logic vs_dly_q, vs_dly_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          pending_q, pending_d;
  logic [9:0]    pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [9:0]    x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic          pos_valid_q, pos_valid_d;
  logic          frame_err_q, frame_err_d, timeout_q, timeout_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic [FRAME_BITS-1:0] word;
  logic [9:0] x_fld, y_fld;
  logic       sck_rise, frame_done, fmt_ok, vs_fall;

  assign word       = {shift_q[FRAME_BITS-2:0], sdi_sync_q};
  assign x_fld      = word[25:16];
  assign y_fld      = word[9:0];
  assign fmt_ok     = (word[31:26] == 6'd0) && (word[15:10] == 6'd0);
  assign sck_rise   = sck_sync_q & ~sck_prev_q;
  assign frame_done = sck_rise && (bit_cnt_q == LAST_BIT);
  assign vs_fall    = vs_dly_q & ~vsync;

  always_comb begin
    sck_meta_d  = sck;
    sck_sync_d  = sck_meta_q;
    sck_prev_d  = sck_sync_q;
    sdi_meta_d  = sdi;
    sdi_sync_d  = sdi_meta_q;
    vs_dly_d    = vsync;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    idle_d      = idle_q;
    pending_d   = pending_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    pos_valid_d = pos_valid_q;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // Commit sees the old pending values; a frame landing this cycle re-arms pending.
    if (vs_fall && pending_q) begin
      x_pos_d     = pend_x_q;
      y_pos_d     = pend_y_q;
      pos_valid_d = 1'b1;
      pending_d   = 1'b0;
    end

    if (sck_rise) begin
      shift_d = word;
      idle_d  = '0;
      if (frame_done) begin
        bit_cnt_d = '0;
        if (fmt_ok) begin
          pend_x_d    = (x_fld > X_MAX) ? X_MAX : x_fld;
          pend_y_d    = (y_fld > Y_MAX) ? Y_MAX : y_fld;
          pending_d   = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (bit_cnt_q != '0) begin
      if (idle_q == IDLE_MAX) begin
        bit_cnt_d = '0;
        idle_d    = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      sdi_meta_q  <= 1'b0;
      sdi_sync_q  <= 1'b0;
      vs_dly_q    <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      pending_q   <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      pos_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_prev_q  <= sck_prev_d;
      sdi_meta_q  <= sdi_meta_d;
      sdi_sync_q  <= sdi_sync_d;
      vs_dly_q    <= vs_dly_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_q      <= idle_d;
      pending_q   <= pending_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      pos_valid_q <= pos_valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign x_pos     = x_pos_q;
  assign y_pos     = y_pos_q;
  assign pos_valid = pos_valid_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;
  assign frame_cnt = frame_cnt_q;
endmodule
